// File: rtl/core_types_pkg.sv
// Shared core constants, the ALU-immediate issue-queue entry record and the
// writeback wakeup-match helper.
package core_types_pkg;

    localparam int LOG_PR_COUNT       = 7;
    localparam int LOG_ROB_ENTRIES    = 7;
    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = 2;
    localparam int UPPER_PR_W         = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    typedef struct packed {
        logic                       valid;
        logic [3:0]                 op;
        logic [11:0]                imm12;
        logic [LOG_PR_COUNT-1:0]    A_PR;
        logic                       A_ready;
        logic                       A_is_zero;
        logic [LOG_PR_COUNT-1:0]    dest_PR;
        logic [LOG_ROB_ENTRIES-1:0] ROB_index;
    } alu_imm_iq_entry_t;

    // A PR's low bits select its bank; the bank broadcasts the remaining upper bits.
    function automatic logic wb_hit(
        input logic [LOG_PR_COUNT-1:0]              pr,
        input logic [PRF_BANK_COUNT-1:0]            valid_by_bank,
        input logic [PRF_BANK_COUNT*UPPER_PR_W-1:0] upper_by_bank
    );
        logic [LOG_PRF_BANK_COUNT-1:0] bank;
        bank = pr[LOG_PRF_BANK_COUNT-1:0];
        return valid_by_bank[bank] &&
               (upper_by_bank[bank*UPPER_PR_W +: UPPER_PR_W] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
    endfunction

endpackage

// File: rtl/pe_lsb.sv
// Priority encoder: index of the least-significant set request bit (0 when none).
module pe_lsb #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/alu_imm_iq.sv
// Age-ordered collapsing issue queue for ALU register-immediate ops with A-operand wakeup.
// Optional macro ALU_IMM_IQ_ENQ_BYPASS_EN lets a ready enqueue issue in its enqueue cycle.
module alu_imm_iq
    import core_types_pkg::*;
#(
    parameter int ALU_IMM_IQ_ENTRIES = 8
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  iq_enq_valid,
    input  logic [3:0]                            iq_enq_op,
    input  logic [11:0]                           iq_enq_imm12,
    input  logic [LOG_PR_COUNT-1:0]               iq_enq_A_PR,
    input  logic                                  iq_enq_A_ready,
    input  logic                                  iq_enq_A_is_zero,
    input  logic [LOG_PR_COUNT-1:0]               iq_enq_dest_PR,
    input  logic [LOG_ROB_ENTRIES-1:0]            iq_enq_ROB_index,
    output logic                                  iq_enq_ready,
    input  logic [PRF_BANK_COUNT-1:0]             WB_bus_valid_by_bank,
    input  logic [PRF_BANK_COUNT*UPPER_PR_W-1:0]  WB_bus_upper_PR_by_bank,
    input  logic                                  issue_ready,
    output logic                                  issue_valid,
    output logic [3:0]                            issue_op,
    output logic [11:0]                           issue_imm12,
    output logic                                  issue_A_forward,
    output logic                                  issue_A_is_zero,
    output logic [LOG_PR_COUNT-1:0]               issue_dest_PR,
    output logic [LOG_ROB_ENTRIES-1:0]            issue_ROB_index,
    output logic                                  PRF_req_A_valid,
    output logic [LOG_PR_COUNT-1:0]               PRF_req_A_PR
);

    localparam int N  = ALU_IMM_IQ_ENTRIES;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    alu_imm_iq_entry_t r_q [N];
    logic [CW-1:0]     r_count;

    alu_imm_iq_entry_t w_up  [N];
    alu_imm_iq_entry_t w_nxt [N];
    alu_imm_iq_entry_t w_enq;
    alu_imm_iq_entry_t w_out;
    logic [N-1:0]      w_hit, w_ready, w_up_hit, w_shift, w_enq_here;
    logic [IW-1:0]     w_sel_idx;
    logic [CW-1:0]     w_enq_slot;
    logic              w_any_ready, w_enq_hit, w_enq_fire, w_enq_write;
    logic              w_byp_cand, w_issue_q, w_out_hit;

    // Survivors fold this cycle's wakeup into A_ready; a new op overrides its slot.
    function automatic alu_imm_iq_entry_t next_entry(
        input alu_imm_iq_entry_t cur,
        input logic              cur_hit,
        input alu_imm_iq_entry_t up,
        input logic              up_hit,
        input logic              shift,
        input alu_imm_iq_entry_t enq,
        input logic              enq_hit,
        input logic              enq_here
    );
        alu_imm_iq_entry_t e;
        logic              h;
        e = shift ? up : cur;
        h = shift ? up_hit : cur_hit;
        e.A_ready = e.A_ready | (e.valid & h);
        if (enq_here) begin
            e = enq;
            e.A_ready = enq.A_ready | enq_hit;
        end
        return e;
    endfunction

    assign iq_enq_ready = ~r_q[N-1].valid;
    assign w_enq_fire   = iq_enq_valid & iq_enq_ready & ~RST;
    assign w_enq_hit    = wb_hit(iq_enq_A_PR, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);

    always_comb begin
        w_enq.valid     = 1'b1;
        w_enq.op        = iq_enq_op;
        w_enq.imm12     = iq_enq_imm12;
        w_enq.A_PR      = iq_enq_A_PR;
        w_enq.A_ready   = iq_enq_A_ready;
        w_enq.A_is_zero = iq_enq_A_is_zero;
        w_enq.dest_PR   = iq_enq_dest_PR;
        w_enq.ROB_index = iq_enq_ROB_index;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            assign w_hit[gi]   = wb_hit(r_q[gi].A_PR, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
            assign w_ready[gi] = r_q[gi].valid & (r_q[gi].A_ready | r_q[gi].A_is_zero | w_hit[gi]);
            if (gi < N - 1) begin : g_up
                assign w_up[gi]     = r_q[gi+1];
                assign w_up_hit[gi] = w_hit[gi+1];
            end else begin : g_top
                assign w_up[gi]     = '0;
                assign w_up_hit[gi] = 1'b0;
            end
            assign w_shift[gi]    = w_issue_q & (gi >= int'(w_sel_idx));
            assign w_enq_here[gi] = w_enq_write & (int'(w_enq_slot) == gi);
            assign w_nxt[gi]      = next_entry(r_q[gi], w_hit[gi], w_up[gi], w_up_hit[gi],
                                               w_shift[gi], w_enq, w_enq_hit, w_enq_here[gi]);
        end
    endgenerate

    pe_lsb #(.WIDTH(N), .IDX_W(IW)) u_pe_lsb (
        .i_req   (w_ready),
        .o_valid (w_any_ready),
        .o_idx   (w_sel_idx)
    );

`ifdef ALU_IMM_IQ_ENQ_BYPASS_EN
    assign w_byp_cand = w_enq_fire & ~w_any_ready & (iq_enq_A_ready | iq_enq_A_is_zero | w_enq_hit);
`else
    assign w_byp_cand = 1'b0;
`endif

    assign w_issue_q   = w_any_ready & issue_ready & ~RST;
    assign issue_valid = (w_any_ready | w_byp_cand) & issue_ready & ~RST;
    // A bypass that the pipeline refuses still lands in the queue.
    assign w_enq_write = w_enq_fire & ~(w_byp_cand & issue_ready);
    assign w_enq_slot  = r_count - CW'(w_issue_q);

    assign w_out     = w_byp_cand ? w_enq : r_q[w_sel_idx];
    assign w_out_hit = w_byp_cand ? w_enq_hit : w_hit[w_sel_idx];

    assign issue_op        = w_out.op;
    assign issue_imm12     = w_out.imm12;
    assign issue_A_is_zero = w_out.A_is_zero;
    assign issue_dest_PR   = w_out.dest_PR;
    assign issue_ROB_index = w_out.ROB_index;
    assign issue_A_forward = w_out.valid & w_out_hit & ~w_out.A_ready & ~w_out.A_is_zero;
    assign PRF_req_A_valid = issue_valid & ~issue_A_is_zero & ~issue_A_forward;
    assign PRF_req_A_PR    = w_out.A_PR;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
            for (int i = 0; i < N; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            r_count <= r_count - CW'(w_issue_q) + CW'(w_enq_write);
            for (int i = 0; i < N; i++) begin
                r_q[i] <= w_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_imm_iq.sv
// Self-checking bench for alu_imm_iq: vector table plus hand sequences, issue-order scoreboard.
module tb_alu_imm_iq;
    import core_types_pkg::*;

`ifdef ALU_IMM_IQ_ENQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int UPW = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    logic                             CLK;
    logic                             RST;
    logic                             iq_enq_valid;
    logic [3:0]                       iq_enq_op;
    logic [11:0]                      iq_enq_imm12;
    logic [LOG_PR_COUNT-1:0]          iq_enq_A_PR;
    logic                             iq_enq_A_ready;
    logic                             iq_enq_A_is_zero;
    logic [LOG_PR_COUNT-1:0]          iq_enq_dest_PR;
    logic [LOG_ROB_ENTRIES-1:0]       iq_enq_ROB_index;
    logic                             iq_enq_ready;
    logic [PRF_BANK_COUNT-1:0]        WB_bus_valid_by_bank;
    logic [PRF_BANK_COUNT*UPW-1:0]    WB_bus_upper_PR_by_bank;
    logic                             issue_ready;
    logic                             issue_valid;
    logic [3:0]                       issue_op;
    logic [11:0]                      issue_imm12;
    logic                             issue_A_forward;
    logic                             issue_A_is_zero;
    logic [LOG_PR_COUNT-1:0]          issue_dest_PR;
    logic [LOG_ROB_ENTRIES-1:0]       issue_ROB_index;
    logic                             PRF_req_A_valid;
    logic [LOG_PR_COUNT-1:0]          PRF_req_A_PR;

    alu_imm_iq #(.ALU_IMM_IQ_ENTRIES(8)) dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .iq_enq_valid            (iq_enq_valid),
        .iq_enq_op               (iq_enq_op),
        .iq_enq_imm12            (iq_enq_imm12),
        .iq_enq_A_PR             (iq_enq_A_PR),
        .iq_enq_A_ready          (iq_enq_A_ready),
        .iq_enq_A_is_zero        (iq_enq_A_is_zero),
        .iq_enq_dest_PR          (iq_enq_dest_PR),
        .iq_enq_ROB_index        (iq_enq_ROB_index),
        .iq_enq_ready            (iq_enq_ready),
        .WB_bus_valid_by_bank    (WB_bus_valid_by_bank),
        .WB_bus_upper_PR_by_bank (WB_bus_upper_PR_by_bank),
        .issue_ready             (issue_ready),
        .issue_valid             (issue_valid),
        .issue_op                (issue_op),
        .issue_imm12             (issue_imm12),
        .issue_A_forward         (issue_A_forward),
        .issue_A_is_zero         (issue_A_is_zero),
        .issue_dest_PR           (issue_dest_PR),
        .issue_ROB_index         (issue_ROB_index),
        .PRF_req_A_valid         (PRF_req_A_valid),
        .PRF_req_A_PR            (PRF_req_A_PR)
    );

    typedef struct {
        logic [3:0]                 op;
        logic [11:0]                imm;
        logic [LOG_PR_COUNT-1:0]    a_pr;
        logic                       a_rdy;
        logic                       a_zero;
        logic [LOG_PR_COUNT-1:0]    dest;
        logic [LOG_ROB_ENTRIES-1:0] rob;
        logic                       fwd;
        logic                       prf;
    } vec_t;

    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        iq_enq_valid            = 1'b0;
        iq_enq_op               = '0;
        iq_enq_imm12            = '0;
        iq_enq_A_PR             = '0;
        iq_enq_A_ready          = 1'b0;
        iq_enq_A_is_zero        = 1'b0;
        iq_enq_dest_PR          = '0;
        iq_enq_ROB_index        = '0;
        WB_bus_valid_by_bank    = '0;
        WB_bus_upper_PR_by_bank = '0;
    endtask

    task automatic enq(input vec_t v);
        iq_enq_valid     = 1'b1;
        iq_enq_op        = v.op;
        iq_enq_imm12     = v.imm;
        iq_enq_A_PR      = v.a_pr;
        iq_enq_A_ready   = v.a_rdy;
        iq_enq_A_is_zero = v.a_zero;
        iq_enq_dest_PR   = v.dest;
        iq_enq_ROB_index = v.rob;
    endtask

    task automatic wb(input logic [LOG_PR_COUNT-1:0] pr);
        int b;
        b = int'(pr[LOG_PRF_BANK_COUNT-1:0]);
        WB_bus_valid_by_bank[b] = 1'b1;
        WB_bus_upper_PR_by_bank[b*UPW +: UPW] = pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Scoreboard: every observed issue must match the next expected op in order.
    always @(negedge CLK) begin
        if (issue_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected actual rob=%0d required none", issue_ROB_index);
            end else begin
                vec_t e;
                e = sb.pop_front();
                if (issue_ROB_index !== e.rob || issue_op !== e.op || issue_imm12 !== e.imm ||
                    issue_dest_PR !== e.dest || issue_A_forward !== e.fwd ||
                    PRF_req_A_valid !== e.prf || issue_A_is_zero !== e.a_zero ||
                    (e.prf && PRF_req_A_PR !== e.a_pr)) begin
                    errors++;
                    $display("FAIL issue_rob%0d actual rob=%0d op=%0h imm=%0h dest=%0h fwd=%0b prf=%0b zero=%0b pr=%0h required rob=%0d op=%0h imm=%0h dest=%0h fwd=%0b prf=%0b zero=%0b pr=%0h",
                             e.rob, issue_ROB_index, issue_op, issue_imm12, issue_dest_PR, issue_A_forward,
                             PRF_req_A_valid, issue_A_is_zero, PRF_req_A_PR,
                             e.rob, e.op, e.imm, e.dest, e.fwd, e.prf, e.a_zero, e.a_pr);
                end else begin
                    $display("ok   issue rob=%0d fwd=%0b prf=%0b", issue_ROB_index, issue_A_forward, PRF_req_A_valid);
                end
            end
        end
    end

    vec_t tbl [5];
    vec_t fill [8];
    vec_t v;

    initial begin
        tbl[0] = '{op:4'h1, imm:12'h001, a_pr:7'h04, a_rdy:1'b1, a_zero:1'b0, dest:7'h11, rob:7'd1,  fwd:1'b0, prf:1'b1};
        tbl[1] = '{op:4'h2, imm:12'h802, a_pr:7'h09, a_rdy:1'b1, a_zero:1'b0, dest:7'h12, rob:7'd2,  fwd:1'b0, prf:1'b1};
        tbl[2] = '{op:4'hF, imm:12'hFFF, a_pr:7'h7E, a_rdy:1'b1, a_zero:1'b0, dest:7'h13, rob:7'd3,  fwd:1'b0, prf:1'b1};
        tbl[3] = '{op:4'h4, imm:12'h123, a_pr:7'h00, a_rdy:1'b0, a_zero:1'b1, dest:7'h14, rob:7'd10, fwd:1'b0, prf:1'b0};
        tbl[4] = '{op:4'h5, imm:12'h456, a_pr:7'h00, a_rdy:1'b0, a_zero:1'b1, dest:7'h15, rob:7'd11, fwd:1'b0, prf:1'b0};

        idle();
        issue_ready = 1'b1;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_enq_ready", iq_enq_ready, 1);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_prf_req", PRF_req_A_valid, 0);
        chk("rst_fwd", issue_A_forward, 0);
        chk("rst_rob", issue_ROB_index, 0);
        chk("rst_dest", issue_dest_PR, 0);
        chk("rst_op_imm", {issue_op, issue_imm12}, 0);
        tick();

        // Ready ops and x0 ops in turn, one enqueue per cycle.
        for (int i = 0; i < 5; i++) begin
            enq(tbl[i]);
            sb.push_back(tbl[i]);
            @(negedge CLK);
            chk($sformatf("t1_enq_ready_%0d", i), iq_enq_ready, 1);
            chk($sformatf("t1_issue_valid_%0d", i), issue_valid, 32'(BYP || i > 0));
            tick();
        end
        idle();
        @(negedge CLK);
        chk("t1_drain_last", issue_valid, 32'(!BYP));
        tick();
        @(negedge CLK);
        chk("t1_empty", issue_valid, 0);
        tick();

        // Younger ready op overtakes; older one issues on its writeback cycle.
        v = '{op:4'h2, imm:12'h055, a_pr:7'h21, a_rdy:1'b0, a_zero:1'b0, dest:7'h25, rob:7'd5, fwd:1'b1, prf:1'b0};
        enq(v);
        @(negedge CLK);
        chk("t2_wait", issue_valid, 0);
        tick();
        fill[0] = '{op:4'h3, imm:12'h066, a_pr:7'h05, a_rdy:1'b1, a_zero:1'b0, dest:7'h26, rob:7'd6, fwd:1'b0, prf:1'b1};
        enq(fill[0]);
        sb.push_back(fill[0]);
        @(negedge CLK);
        chk("t2_enq6", issue_valid, 32'(BYP));
        tick();
        idle();
        @(negedge CLK);
        chk("t2_rob6", issue_valid, 32'(!BYP));
        tick();
        wb(7'h21);
        sb.push_back(v);
        @(negedge CLK);
        chk("t2_fwd", issue_A_forward, 1);
        chk("t2_prf_req", PRF_req_A_valid, 0);
        chk("t2_rob5", issue_ROB_index, 5);
        tick();
        idle();

        // Fill all eight with non-ready ops.
        for (int i = 0; i < 8; i++) begin
            fill[i] = '{op:4'(i), imm:12'h300 + 12'(i), a_pr:7'h40 + 7'(i), a_rdy:1'b0, a_zero:1'b0,
                        dest:7'h30 + 7'(i), rob:7'd20 + 7'(i), fwd:1'b1, prf:1'b0};
            enq(fill[i]);
            @(negedge CLK);
            chk($sformatf("t3_fill_%0d", i), issue_valid, 0);
            tick();
        end
        idle();
        wb(7'h43);
        v = '{op:4'h9, imm:12'h999, a_pr:7'h01, a_rdy:1'b1, a_zero:1'b0, dest:7'h63, rob:7'd99, fwd:1'b0, prf:1'b1};
        enq(v);
        sb.push_back(fill[3]);
        @(negedge CLK);
        chk("t3_full_enq_ready", iq_enq_ready, 0);
        chk("t3_full_issue", issue_valid, 1);
        tick();
        idle();
        @(negedge CLK);
        chk("t3_reopen", iq_enq_ready, 1);
        chk("t3_idle", issue_valid, 0);
        tick();
        // Two wakeups at once: oldest forwards now, the other keeps A_ready.
        wb(7'h44);
        wb(7'h47);
        sb.push_back(fill[4]);
        fill[7].fwd = 1'b0;
        fill[7].prf = 1'b1;
        sb.push_back(fill[7]);
        @(negedge CLK);
        chk("t3_shift_rob", issue_ROB_index, 24);
        tick();
        idle();
        @(negedge CLK);
        chk("t3_accum", issue_valid, 1);
        tick();

        // Pipeline stalled while entry 0 is woken.
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle();
            wb(7'h40);
            @(negedge CLK);
            chk($sformatf("t5_stall_%0d", k), issue_valid, 0);
            tick();
        end
        issue_ready = 1'b1;
        idle();
        fill[0].fwd = 1'b0;
        fill[0].prf = 1'b1;
        sb.push_back(fill[0]);
        @(negedge CLK);
        chk("t5_fwd", issue_A_forward, 0);
        chk("t5_prf_req", PRF_req_A_valid, 1);
        tick();

        // Five entries valid, reset with an enqueue pending.
        v = '{op:4'h6, imm:12'h030, a_pr:7'h50, a_rdy:1'b0, a_zero:1'b0, dest:7'h50, rob:7'd30, fwd:1'b1, prf:1'b0};
        enq(v);
        tick();
        RST = 1'b1;
        v = '{op:4'h7, imm:12'h031, a_pr:7'h51, a_rdy:1'b1, a_zero:1'b0, dest:7'h51, rob:7'd31, fwd:1'b0, prf:1'b1};
        enq(v);
        @(negedge CLK);
        chk("t6_rst_cycle_issue", issue_valid, 0);
        tick();
        RST = 1'b0;
        idle();
        @(negedge CLK);
        chk("t6_enq_ready", iq_enq_ready, 1);
        chk("t6_issue_valid", issue_valid, 0);
        chk("t6_rob", issue_ROB_index, 0);
        tick();

        // Empty queue plus ready enqueue.
        v = '{op:4'hA, imm:12'h040, a_pr:7'h11, a_rdy:1'b1, a_zero:1'b0, dest:7'h40, rob:7'd40, fwd:1'b0, prf:1'b1};
        enq(v);
        sb.push_back(v);
        @(negedge CLK);
        chk("byp_same_cycle", issue_valid, 32'(BYP));
        tick();
        idle();
        @(negedge CLK);
        chk("byp_next_cycle", issue_valid, 32'(!BYP));
        tick();

        // Queue must hold eight fresh ops, proving the reset emptied it.
        for (int i = 0; i < 8; i++) begin
            v = '{op:4'hB, imm:12'(i), a_pr:7'h60 + 7'(i), a_rdy:1'b0, a_zero:1'b0,
                  dest:7'(i), rob:7'd50 + 7'(i), fwd:1'b1, prf:1'b0};
            enq(v);
            @(negedge CLK);
            chk($sformatf("t6_refill_ready_%0d", i), iq_enq_ready, 1);
            tick();
        end
        idle();
        @(negedge CLK);
        chk("t6_refill_full", iq_enq_ready, 0);
        tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained actual pending=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
